// File: rtl/uart_rx_stream.sv
// UART 8N1 receiver with glitch-rejecting start detect and a small
// first-word-fall-through FIFO on the valid/ready byte output.
module uart_rx_stream #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_pin,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] DEPTH = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync2_q;
    logic [15:0]     cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            push_req;
    logic            ferr_d, frame_err_q;
    logic            ovr_d, overrun_q;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            pop;
    logic            full;
    logic            push_ok;
    logic            rx_s;

    assign rx_s = sync2_q;

    // Two-flop synchroniser; idles high so reset looks like an idle line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_pin;
            sync2_q <= sync1_q;
        end
    end

    // Frame FSM state, baud counter, bit index and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= ferr_d;
            overrun_q   <= ovr_d;
        end
    end

    // Next-state logic: mid-bit sampling, counter cleared on every transition.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 16'd1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push_req = 1'b0;
        ferr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push_req = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BRK;
                    end
                end
            end
            BRK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign full    = (level_q == DEPTH);
    assign pop     = rx_valid && rx_ready;
    assign push_ok = push_req && (!full || pop);

    // FIFO pointer and level update; a push into a full FIFO needs a same-cycle pop.
    always_comb begin
        ovr_d    = push_req && full && !pop;
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push_ok) - LW'(pop);
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= shift_q;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign rx_valid   = (level_q != '0);
    assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign fifo_level = level_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream at 16 clocks per bit, 4-deep FIFO.
// Bytes are driven on rx_pin bit by bit; results checked with assertions.
module tb_uart_rx_stream;

    localparam int CPB = 16;
    localparam int DEP = 4;

    logic       clk;
    logic       rst_n;
    logic       rx_pin;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic [2:0] fifo_level;

    int total;
    int bad;
    int ferr_cnt;
    int ovr_cnt;
    int pop_cnt;
    int f0, o0, p0;

    uart_rx_stream #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_pin    (rx_pin),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .fifo_level(fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (rx_valid && rx_ready) pop_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start bit begins 1 time unit after the next posedge (P0);
    // stop sample lands on edge P0+155 with CPB=16.
    task automatic send(input logic [7:0] b, input logic stopv);
        @(posedge clk);
        #1 rx_pin = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rx_pin = b[i];
        end
        repeat (CPB) @(posedge clk);
        #1 rx_pin = stopv;
        repeat (CPB) @(posedge clk);
        #1 rx_pin = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input int n);
        logic [7:0] exp [4];
        exp[0] = a;
        exp[1] = b;
        exp[2] = c;
        exp[3] = d;
        rx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, {24'd0, rx_data}, {24'd0, exp[i]});
            @(posedge clk);
            #1;
        end
        rx_ready = 1'b0;
        chk({tag, "_empty"}, {29'd0, fifo_level}, 32'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        ferr_cnt = 0;
        ovr_cnt  = 0;
        pop_cnt  = 0;
        rx_pin   = 1'b1;
        rx_ready = 1'b0;
        rst_n    = 1'b0;
        idle(3);
        chk("rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_data", {24'd0, rx_data}, 32'd0);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        idle(5);

        // Single byte with consumer ready: one valid cycle, 1 clk after stop.
        rx_ready = 1'b1;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        p0 = pop_cnt;
        fork
            send(8'hA5, 1'b1);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1 chk("t1_pre", {31'd0, rx_valid}, 32'd0);
                @(posedge clk);
                #1 chk("t1_valid", {31'd0, rx_valid}, 32'd1);
                chk("t1_data", {24'd0, rx_data}, 32'hA5);
                @(posedge clk);
                #1 chk("t1_post", {31'd0, rx_valid}, 32'd0);
            end
        join
        idle(4);
        chk("t1_pops", pop_cnt - p0, 32'd1);
        chk("t1_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 32'd0);
        rx_ready = 1'b0;

        // Three bytes buffered, head held, then drained back to back.
        send(8'h00, 1'b1);
        chk("t2_head1", {24'd0, rx_data}, 32'h00);
        send(8'hFF, 1'b1);
        send(8'h3C, 1'b1);
        idle(4);
        chk("t2_level", {29'd0, fifo_level}, 32'd3);
        chk("t2_head3", {24'd0, rx_data}, 32'h00);
        chk("t2_valid", {31'd0, rx_valid}, 32'd1);
        drain("t2", 8'h00, 8'hFF, 8'h3C, 8'h00, 3);

        // Fifth byte into a full FIFO is dropped with one overrun pulse.
        o0 = ovr_cnt;
        send(8'h11, 1'b1);
        send(8'h12, 1'b1);
        send(8'h13, 1'b1);
        send(8'h14, 1'b1);
        send(8'h15, 1'b1);
        idle(4);
        chk("t3_ovr", ovr_cnt - o0, 32'd1);
        chk("t3_level", {29'd0, fifo_level}, 32'd4);
        drain("t3", 8'h11, 8'h12, 8'h13, 8'h14, 4);

        // Same again, but a pop coincides with the fifth push.
        o0 = ovr_cnt;
        send(8'h11, 1'b1);
        send(8'h12, 1'b1);
        send(8'h13, 1'b1);
        send(8'h14, 1'b1);
        fork
            send(8'h15, 1'b1);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        idle(4);
        chk("t3b_ovr", ovr_cnt - o0, 32'd0);
        chk("t3b_level", {29'd0, fifo_level}, 32'd4);
        drain("t3b", 8'h12, 8'h13, 8'h14, 8'h15, 4);

        // Stop bit low: one frame_err, nothing pushed.
        f0 = ferr_cnt;
        send(8'h5A, 1'b0);
        idle(4);
        chk("t4_ferr", ferr_cnt - f0, 32'd1);
        chk("t4_level", {29'd0, fifo_level}, 32'd0);

        // Break of 30 bit times gives a single frame_err, then 0x55 arrives.
        f0 = ferr_cnt;
        rx_pin = 1'b0;
        idle(30 * CPB);
        rx_pin = 1'b1;
        idle(2 * CPB);
        send(8'h55, 1'b1);
        idle(4);
        chk("t4b_ferr", ferr_cnt - f0, 32'd1);
        chk("t4b_level", {29'd0, fifo_level}, 32'd1);
        drain("t4b", 8'h55, 8'h00, 8'h00, 8'h00, 1);

        // Short low glitch is rejected; the next byte still decodes.
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        rx_pin = 1'b0;
        idle(CPB / 4);
        rx_pin = 1'b1;
        idle(2 * CPB);
        chk("t5_level", {29'd0, fifo_level}, 32'd0);
        chk("t5_flags", (ferr_cnt - f0) + (ovr_cnt - o0), 32'd0);
        send(8'h96, 1'b1);
        idle(4);
        drain("t5", 8'h96, 8'h00, 8'h00, 8'h00, 1);

        // Reset asserted during data bit 4 clears outputs at once.
        send(8'h77, 1'b1);
        idle(2);
        chk("t6_pre", {29'd0, fifo_level}, 32'd1);
        fork
            send(8'h5A, 1'b1);
            begin
                @(posedge clk);
                repeat (90) @(posedge clk);
                #1 rst_n = 1'b0;
                #1;
                chk("t6_valid", {31'd0, rx_valid}, 32'd0);
                chk("t6_data", {24'd0, rx_data}, 32'd0);
                chk("t6_level", {29'd0, fifo_level}, 32'd0);
                chk("t6_outs", {30'd0, frame_err, overrun}, 32'd0);
            end
        join
        idle(4);
        rst_n = 1'b1;
        idle(4);
        f0 = ferr_cnt;
        send(8'hC3, 1'b1);
        idle(4);
        chk("t6_rx_level", {29'd0, fifo_level}, 32'd1);
        chk("t6_rx_ferr", ferr_cnt - f0, 32'd0);
        drain("t6", 8'hC3, 8'h00, 8'h00, 8'h00, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
